// File: rtl/dual_fetch_buffer.sv
// Dual-issue fetch buffer: issues 64-bit fetches and queues (PC, instr) pairs in order.
// The FETCH_PERF_EN macro adds the starve_cnt_o stall counter.

module dual_fetch_slot (
  input  logic        vld_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic [31:0] pcp4_o
);
  assign pc_o    = vld_i ? pc_i : '0;
  assign instr_o = vld_i ? instr_i : '0;
  assign pcp4_o  = vld_i ? pc_i + 32'd4 : '0;
endmodule

module dual_fetch_buffer #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [63:0] imem_rsp_data_i,
  input  logic [1:0]  deq_i,
`ifdef FETCH_PERF_EN
  output logic [31:0] starve_cnt_o,
`endif
  output logic        valid1_o,
  output logic        valid2_o,
  output logic [31:0] PCF1,
  output logic [31:0] InstrF1,
  output logic [31:0] PCPlus4F1,
  output logic [31:0] PCF2,
  output logic [31:0] InstrF2,
  output logic [31:0] PCPlus4F2
);
  localparam int AW        = $clog2(DEPTH);
  localparam int NUM_LANES = 2;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e                      state_q;
  logic [31:0]                 fetch_pc_q, req_addr_q;
  logic                        req_valid_q, stale_q;
  logic [AW:0]                 count_q, count_d, free, deq_ext, deq_eff;
  logic [AW-1:0]               rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [DEPTH-1:0][31:0]      pc_mem_q, ins_mem_q;
  logic                        wr_en;
  logic [NUM_LANES-1:0]        slot_vld;
  logic [NUM_LANES-1:0][31:0]  slot_pc, slot_ins, slot_pcp4;

  assign free    = DEPTH_C - count_q;
  assign deq_ext = {{(AW-1){1'b0}}, deq_i};
  // A response raced by a redirect in the same cycle is dropped, like a stale one.
  assign wr_en   = (state_q == WAIT) && imem_rsp_valid_i && !stale_q && !redirect_i;

  always_comb begin
    deq_eff  = '0;
    count_d  = '0;
    rd_ptr_d = wr_ptr_q;
    wr_ptr_d = wr_ptr_q + (wr_en ? AW'(2) : AW'(0));
    if (!redirect_i) begin
      deq_eff  = (deq_ext > count_q) ? count_q : deq_ext;
      count_d  = count_q + (wr_en ? (AW+1)'(2) : (AW+1)'(0)) - deq_eff;
      rd_ptr_d = rd_ptr_q + AW'(deq_eff);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      req_addr_q  <= '0;
      req_valid_q <= 1'b0;
      stale_q     <= 1'b0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      if (redirect_i) fetch_pc_q <= redirect_pc_i & ~32'h3;
      unique case (state_q)
        IDLE: if (!redirect_i && free >= (AW+1)'(2)) begin
          state_q     <= REQ;
          req_valid_q <= 1'b1;
          req_addr_q  <= fetch_pc_q;
        end
        REQ: begin
          // The request stays up across a redirect; its response is marked stale.
          if (redirect_i) stale_q <= 1'b1;
          if (imem_req_ready_i) begin
            state_q     <= WAIT;
            req_valid_q <= 1'b0;
            if (!redirect_i) fetch_pc_q <= fetch_pc_q + 32'd8;
          end
        end
        WAIT: begin
          if (imem_rsp_valid_i) begin
            state_q <= IDLE;
            stale_q <= 1'b0;
          end else if (redirect_i) begin
            stale_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem_q[wr_ptr_q]           <= req_addr_q;
      ins_mem_q[wr_ptr_q]          <= imem_rsp_data_i[31:0];
      pc_mem_q[wr_ptr_q + AW'(1)]  <= req_addr_q + 32'd4;
      ins_mem_q[wr_ptr_q + AW'(1)] <= imem_rsp_data_i[63:32];
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && !redirect_i) assert (deq_ext <= count_q);
  end
`endif

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [AW-1:0] idx;
    assign idx         = rd_ptr_q + AW'(l);
    assign slot_vld[l] = (count_q > (AW+1)'(l));
    dual_fetch_slot u_slot (
      .vld_i  (slot_vld[l]),
      .pc_i   (pc_mem_q[idx]),
      .instr_i(ins_mem_q[idx]),
      .pc_o   (slot_pc[l]),
      .instr_o(slot_ins[l]),
      .pcp4_o (slot_pcp4[l])
    );
  end

  assign imem_req_valid_o = req_valid_q;
  assign imem_req_addr_o  = req_addr_q;
  assign valid1_o  = slot_vld[0];
  assign valid2_o  = slot_vld[1];
  assign PCF1      = slot_pc[0];
  assign InstrF1   = slot_ins[0];
  assign PCPlus4F1 = slot_pcp4[0];
  assign PCF2      = slot_pc[1];
  assign InstrF2   = slot_ins[1];
  assign PCPlus4F2 = slot_pcp4[1];

`ifdef FETCH_PERF_EN
  logic [31:0] starve_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else if (!slot_vld[0] && starve_q != 32'hFFFF_FFFF) starve_q <= starve_q + 32'd1;
  end
  assign starve_cnt_o = starve_q;
`endif
endmodule

// File: tb/tb_dual_fetch_buffer.sv
// Directed bench for dual_fetch_buffer: a memory responder feeds a queue model of the FIFO.
module tb_dual_fetch_buffer;
  typedef struct packed { logic [31:0] pc; logic [31:0] ins; } ent_t;

  logic clk = 1'b0;
  logic rst_n, redirect, ready, rsp_valid, req_valid, valid1, valid2;
  logic [31:0] redirect_pc, addr, PCF1, InstrF1, PCPlus4F1, PCF2, InstrF2, PCPlus4F2;
  logic [63:0] rsp_data;
  logic [1:0]  deq;
`ifdef FETCH_PERF_EN
  logic [31:0] starve_cnt;
`endif

  int checks = 0, failures = 0;
  int cd = -1, rsp_lat = 1;
  logic drop_next = 1'b0;
  ent_t q[$];
  logic [31:0] req_log[$];

  always #5 clk = ~clk;

  dual_fetch_buffer dut (
    .clk(clk), .rst_n(rst_n), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_valid_o(req_valid), .imem_req_ready_i(ready), .imem_req_addr_o(addr),
    .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data), .deq_i(deq),
`ifdef FETCH_PERF_EN
    .starve_cnt_o(starve_cnt),
`endif
    .valid1_o(valid1), .valid2_o(valid2),
    .PCF1(PCF1), .InstrF1(InstrF1), .PCPlus4F1(PCPlus4F1),
    .PCF2(PCF2), .InstrF2(InstrF2), .PCPlus4F2(PCPlus4F2)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_slots();
    logic v0, v1;
    ent_t e0, e1;
    v0 = q.size() >= 1;
    v1 = q.size() >= 2;
    e0 = v0 ? q[0] : '0;
    e1 = v1 ? q[1] : '0;
    chk("valid1", {31'b0, valid1}, {31'b0, v0});
    chk("valid2", {31'b0, valid2}, {31'b0, v1});
    chk("PCF1", PCF1, e0.pc);
    chk("InstrF1", InstrF1, e0.ins);
    chk("PCPlus4F1", PCPlus4F1, v0 ? e0.pc + 32'd4 : 32'd0);
    chk("PCF2", PCF2, e1.pc);
    chk("InstrF2", InstrF2, e1.ins);
    chk("PCPlus4F2", PCPlus4F2, v1 ? e1.pc + 32'd4 : 32'd0);
  endtask

  // One clock: apply the current deq/redirect to the model, then compare slots.
  task automatic step();
    int d;
    logic r;
    d = int'(deq);
    r = redirect;
    @(posedge clk); #2;
    if (!rst_n || r) q.delete();
    else repeat (d) if (q.size() > 0) void'(q.pop_front());
    check_slots();
  endtask

  // Memory: samples the handshake mid-cycle, answers rsp_lat cycles after accept.
  initial begin : mem
    logic hs, fired;
    logic [31:0] a, ra;
    rsp_valid = 1'b0; rsp_data = '0; fired = 1'b0; a = '0; ra = '0;
    forever begin
      @(negedge clk);
      hs = rst_n && req_valid && ready;
      if (hs) begin a = addr; req_log.push_back(addr); end
      @(posedge clk); #1;
      if (fired) begin
        if (drop_next) drop_next = 1'b0;
        else begin
          q.push_back('{pc: ra, ins: instr_of(ra)});
          q.push_back('{pc: ra + 32'd4, ins: instr_of(ra + 32'd4)});
        end
      end
      fired = 1'b0;
      rsp_valid = 1'b0;
      if (hs) cd = rsp_lat;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          rsp_valid = 1'b1;
          rsp_data  = {instr_of(a + 32'd4), instr_of(a)};
          fired = 1'b1; ra = a; cd = -1;
        end
      end
    end
  end

  initial begin
    int n, base;
    logic [31:0] old2;
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; ready = 1'b0; deq = 2'd0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
    chk("rst_addr", addr, 32'd0);
    check_slots();
`ifdef FETCH_PERF_EN
    chk("rst_starve", starve_cnt, 32'd0);
`endif
    rst_n = 1'b1;

    // 1: request held while not ready, then fill to DEPTH
    step();
    chk("t1_req_up", {31'b0, req_valid}, 32'd1);
    chk("t1_addr0", addr, 32'd0);
    repeat (2) begin
      step();
      chk("t1_req_held", {31'b0, req_valid}, 32'd1);
      chk("t1_addr_held", addr, 32'd0);
    end
    ready = 1'b1;
    repeat (25) step();
    chk("t1_nreq", req_log.size(), 32'd4);
    chk("t1_a0", req_log[0], 32'h0);
    chk("t1_a1", req_log[1], 32'h8);
    chk("t1_a2", req_log[2], 32'h10);
    chk("t1_a3", req_log[3], 32'h18);
    chk("t1_PCF1", PCF1, 32'h0);
    chk("t1_PCF2", PCF2, 32'h4);
    chk("t1_PCPlus4F2", PCPlus4F2, 32'h8);
    repeat (5) step();
    chk("t1_full_noreq", {31'b0, req_valid}, 32'd0);
    chk("t1_full_nreq", req_log.size(), 32'd4);

    // 2: pop two from full, request follows one cycle later
    deq = 2'd2; step(); deq = 2'd0;
    chk("t2_idle", {31'b0, req_valid}, 32'd0);
    step();
    chk("t2_req", {31'b0, req_valid}, 32'd1);
    chk("t2_addr", addr, 32'h20);
    repeat (6) step();
    chk("t2_nreq", req_log.size(), 32'd5);
    chk("t2_PCF1", PCF1, 32'h8);

    // 3: pop one from full
    old2 = PCF2;
    deq = 2'd1; step(); deq = 2'd0;
    chk("t3_PCF1", PCF1, old2);
    chk("t3_PCF2", PCF2, old2 + 32'd4);
    repeat (3) step();
    chk("t3_noreq", {31'b0, req_valid}, 32'd0);

    // 4: redirect while waiting; stale response must vanish
    rsp_lat = 3;
    deq = 2'd2; step(); deq = 2'd0;
    n = 0;
    while (cd <= 0 && n < 10) begin step(); n++; end
    chk("t4_in_wait", {31'b0, cd > 0}, 32'd1);
    base = req_log.size();
    redirect = 1'b1; redirect_pc = 32'h1002;
    drop_next = req_valid || (cd > 0);
    step(); redirect = 1'b0;
    chk("t4_flush_v1", {31'b0, valid1}, 32'd0);
    repeat (3) step();
    chk("t4_stale_v1", {31'b0, valid1}, 32'd0);
    n = 0;
    while (req_log.size() <= base && n < 20) begin step(); n++; end
    chk("t4_new_addr", (req_log.size() > base) ? req_log[base] : 32'hDEAD_BEEF, 32'h1000);
    n = 0;
    while (!valid1 && n < 20) begin step(); n++; end
    chk("t4_PCF1", PCF1, 32'h1000);
    chk("t4_PCF2", PCF2, 32'h1004);

    // 5: redirect coincident with a response and deq=2
    rsp_lat = 1;
    n = 0;
    while (!(rsp_valid && q.size() >= 2) && n < 20) begin step(); n++; end
    chk("t5_rsp_seen", {31'b0, rsp_valid}, 32'd1);
    base = req_log.size();
    redirect = 1'b1; redirect_pc = 32'h2000; deq = 2'd2;
    drop_next = req_valid || (cd > 0);
    step(); redirect = 1'b0; deq = 2'd0;
    chk("t5_v1", {31'b0, valid1}, 32'd0);
    chk("t5_v2", {31'b0, valid2}, 32'd0);
    n = 0;
    while (req_log.size() <= base && n < 20) begin step(); n++; end
    chk("t5_new_addr", (req_log.size() > base) ? req_log[base] : 32'hDEAD_BEEF, 32'h2000);
    n = 0;
    while (!valid1 && n < 20) begin step(); n++; end
    chk("t5_PCF1", PCF1, 32'h2000);

    // 6: async reset mid-WAIT, late response lands during reset
    rsp_lat = 4;
    n = 0;
    while (cd <= 0 && n < 20) begin step(); n++; end
    chk("t6_in_wait", {31'b0, cd > 0}, 32'd1);
    rst_n = 1'b0; drop_next = 1'b1; q.delete();
    #1;
    chk("t6_req_valid", {31'b0, req_valid}, 32'd0);
    chk("t6_addr", addr, 32'd0);
    check_slots();
`ifdef FETCH_PERF_EN
    chk("t6_starve_rst", starve_cnt, 32'd0);
`endif
    base = req_log.size();
    repeat (6) step();
    chk("t6_noreq", req_log.size(), base);
    rst_n = 1'b1; rsp_lat = 1;
    n = 0;
    while (req_log.size() <= base && n < 20) begin step(); n++; end
    chk("t6_new_addr", (req_log.size() > base) ? req_log[base] : 32'hDEAD_BEEF, 32'h0);
    n = 0;
    while (!valid1 && n < 20) begin step(); n++; end
    chk("t6_PCF1", PCF1, 32'h0);

`ifdef FETCH_PERF_EN
    begin
      logic [31:0] s0;
      redirect = 1'b1; redirect_pc = 32'h3000;
      step();
      s0 = starve_cnt;
      step(); step();
      chk("perf_count", starve_cnt, s0 + 32'd2);
      force dut.starve_q = 32'hFFFF_FFFE;
      step();
      release dut.starve_q;
      repeat (3) step();
      chk("perf_sat", starve_cnt, 32'hFFFF_FFFF);
      redirect = 1'b0;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
